time_keeper: RTL and testbench



---
 rtl/clock_pkg.sv | 14 +
 rtl/bcd_mod_counter.sv | 56 +++++
 rtl/time_keeper.sv | 104 ++++++++++
 tb/tb_time_keeper.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day core: FSM encoding, field moduli, BCD digit type.
// Pure declarations; no logic, no latency, no flow control.
package clock_pkg;
   typedef enum logic {
      ST_RUN = 1'b0,
      ST_SET = 1'b1
   } state_t;

   localparam int SEC_MOD = 60;
   localparam int MIN_MOD = 60;
   localparam int HR_MOD  = 24;

   typedef logic [3:0] bcd_t;
endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD-1; registered digits, 1 clk from inc/clr.
// No backpressure: inc is applied on every edge it is high; wrap is combinational.
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic clk,
   input  logic RESETn,
   input  logic clr,
   input  logic inc,
   output bcd_t tens,
   output bcd_t ones,
   output logic wrap
);
   localparam bcd_t TENS_MAX = bcd_t'((MOD - 1) / 10);
   localparam bcd_t ONES_MAX = bcd_t'((MOD - 1) % 10);

   bcd_t tens_q, tens_d;
   bcd_t ones_q, ones_d;
   logic at_max;

   always_comb begin
      at_max = (tens_q == TENS_MAX) && (ones_q == ONES_MAX);
      wrap   = inc & at_max;
      tens_d = tens_q;
      ones_d = ones_q;
      if (clr) begin
         tens_d = '0;
         ones_d = '0;
      end else if (inc) begin
         if (at_max) begin
            tens_d = '0;
            ones_d = '0;
         end else if (ones_q == 4'd9) begin
            tens_d = tens_q + 4'd1;
            ones_d = '0;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RESETn) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens = tens_q;
   assign ones = ones_q;
endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day with tap prescaler and SET mode; digits update 1 clk after the sampled tap edge.
// No backpressure: tap edges and inc pulses are consumed on the cycle they arrive.
module time_keeper
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 381,
   parameter int PRE_W         = $clog2(TICKS_PER_SEC)
) (
   input  logic       clk,
   input  logic       RESETn,
   input  logic       tick_src,
   input  logic       set_mode,
   input  logic       inc_min,
   input  logic       inc_hour,
   output logic       sec_pulse,
   output logic [3:0] hh_t,
   output logic [3:0] hh_o,
   output logic [3:0] mm_t,
   output logic [3:0] mm_o,
   output logic [3:0] ss_t,
   output logic [3:0] ss_o,
   output logic       in_set
);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

   state_t           state_q, state_d;
   logic             tick_q;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic             sec_pulse_q, sec_pulse_d;

   logic tick_rise;
   logic sec_en;
   logic ss_clr;
   logic mm_inc, hh_inc;
   logic ss_wrap, mm_wrap, hh_wrap;

   // SET entry takes priority over a coincident second rollover.
   always_comb begin
      tick_rise   = tick_src & ~tick_q;
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      sec_en      = 1'b0;
      ss_clr      = 1'b0;
      if (state_q == ST_RUN) begin
         if (set_mode) begin
            state_d   = ST_SET;
            pre_cnt_d = '0;
            ss_clr    = 1'b1;
         end else if (tick_rise) begin
            if (pre_cnt_q == PRE_MAX) begin
               pre_cnt_d = '0;
               sec_en    = 1'b1;
            end else begin
               pre_cnt_d = pre_cnt_q + 1'b1;
            end
         end
      end else begin
         pre_cnt_d = '0;
         if (!set_mode) begin
            state_d = ST_RUN;
         end
      end
      sec_pulse_d = sec_en;
   end

   // In SET the minute and hour fields step independently from the buttons.
   assign mm_inc = (state_q == ST_RUN) ? ss_wrap : inc_min;
   assign hh_inc = (state_q == ST_RUN) ? mm_wrap : inc_hour;

   always_ff @(posedge clk) begin
      tick_q <= tick_src;
      if (RESETn) begin
         state_q     <= ST_RUN;
         pre_cnt_q   <= '0;
         sec_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         sec_pulse_q <= sec_pulse_d;
      end
   end

   bcd_mod_counter #(.MOD(SEC_MOD)) u_ss (
      .clk(clk), .RESETn(RESETn), .clr(ss_clr), .inc(sec_en),
      .tens(ss_t), .ones(ss_o), .wrap(ss_wrap)
   );

   bcd_mod_counter #(.MOD(MIN_MOD)) u_mm (
      .clk(clk), .RESETn(RESETn), .clr(1'b0), .inc(mm_inc),
      .tens(mm_t), .ones(mm_o), .wrap(mm_wrap)
   );

   bcd_mod_counter #(.MOD(HR_MOD)) u_hh (
      .clk(clk), .RESETn(RESETn), .clr(1'b0), .inc(hh_inc),
      .tens(hh_t), .ones(hh_o), .wrap(hh_wrap)
   );

   // While running, the hour field can only wrap as part of a full-day cascade.
   a_day_cascade: assert property (@(posedge clk) disable iff (RESETn)
      (hh_wrap && state_q == ST_RUN) |-> mm_wrap);

   assign sec_pulse = sec_pulse_q;
   assign in_set    = (state_q == ST_SET);
endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper with TICKS_PER_SEC=4 against a seconds-of-day reference model.
module tb_time_keeper;
   localparam int TPS = 4;

   logic       clk = 1'b0;
   logic       RESETn, tick_src, set_mode, inc_min, inc_hour;
   logic       sec_pulse, in_set;
   logic [3:0] hh_t, hh_o, mm_t, mm_o, ss_t, ss_o;
   logic [23:0] dut_d;

   time_keeper #(.TICKS_PER_SEC(TPS)) dut (
      .clk(clk), .RESETn(RESETn), .tick_src(tick_src), .set_mode(set_mode),
      .inc_min(inc_min), .inc_hour(inc_hour), .sec_pulse(sec_pulse),
      .hh_t(hh_t), .hh_o(hh_o), .mm_t(mm_t), .mm_o(mm_o), .ss_t(ss_t), .ss_o(ss_o),
      .in_set(in_set)
   );

   assign dut_d = {hh_t, hh_o, mm_t, mm_o, ss_t, ss_o};

   always #10 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: time as seconds since midnight, prescaler as a plain count.
   int m_tod, m_pre;
   bit m_set, m_pulse, m_prev;
   int dut_pulses, mdl_pulses;

   function automatic logic [23:0] tod_digits(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic model_step();
      bit rise;
      int h, m;
      rise = tick_src && !m_prev;
      if (RESETn) begin
         m_tod = 0; m_pre = 0; m_set = 0; m_pulse = 0;
      end else if (!m_set) begin
         m_pulse = 0;
         if (set_mode) begin
            m_set = 1;
            m_tod = m_tod - (m_tod % 60);
            m_pre = 0;
         end else if (rise) begin
            if (m_pre == TPS - 1) begin
               m_pre = 0;
               m_tod = (m_tod + 1) % 86400;
               m_pulse = 1;
            end else begin
               m_pre = m_pre + 1;
            end
         end
      end else begin
         m_pulse = 0;
         h = m_tod / 3600;
         m = (m_tod / 60) % 60;
         if (inc_min)  m = (m + 1) % 60;
         if (inc_hour) h = (h + 1) % 24;
         m_tod = h * 3600 + m * 60 + (m_tod % 60);
         if (!set_mode) m_set = 0;
      end
      m_prev = tick_src;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      dut_pulses += int'(sec_pulse);
      mdl_pulses += int'(m_pulse);
   endtask

   task automatic edges(input int n);
      for (int i = 0; i < n; i++) begin
         tick_src = 1'b1;
         repeat (3) cyc();
         tick_src = 1'b0;
         repeat (5) cyc();
      end
   endtask

   task automatic pulse_inc(input bit m, input bit h);
      inc_min = m;
      inc_hour = h;
      cyc();
      inc_min = 1'b0;
      inc_hour = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
   endtask

   task automatic do_reset();
      RESETn = 1'b1;
      cyc();
      RESETn = 1'b0;
      set_mode = 1'b0;
      inc_min = 1'b0;
      inc_hour = 1'b0;
   endtask

   task automatic test_reset();
      {tick_src, set_mode, inc_min, inc_hour} = 4'($urandom);
      do_reset();
      n_cmp++;
      if ({dut_d, sec_pulse, in_set} !== 26'd0) begin
         n_bad++;
         $display("FAIL reset_state: got %h/%b/%b want 000000/0/0", dut_d, sec_pulse, in_set);
      end
      tick_src = 1'b0;
      cyc();
   endtask

   task automatic test_seconds();
      dut_pulses = 0;
      edges(3);
      n_cmp++;
      if (dut_pulses !== 0 || dut_d !== 24'h000000) begin
         n_bad++;
         $display("FAIL early_sec: got %h pulses=%0d want 000000 pulses=0", dut_d, dut_pulses);
      end
      tick_src = 1'b1;
      cyc();
      n_cmp++;
      if (sec_pulse !== 1'b1 || {ss_t, ss_o} !== 8'h01) begin
         n_bad++;
         $display("FAIL sec_latency: got pulse=%b ss=%h want pulse=1 ss=01", sec_pulse, {ss_t, ss_o});
      end
      cyc();
      n_cmp++;
      if (sec_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL sec_pulse_width: got %b want 0", sec_pulse);
      end
      cyc();
      tick_src = 1'b0;
      repeat (5) cyc();
      edges(36);
      n_cmp++;
      if (dut_d !== 24'h000010 || dut_pulses !== 10) begin
         n_bad++;
         $display("FAIL forty_edges: got %h pulses=%0d want 000010 pulses=10", dut_d, dut_pulses);
      end
   endtask

   task automatic test_hold_high();
      dut_pulses = 0;
      tick_src = 1'b1;
      repeat (100) cyc();
      tick_src = 1'b0;
      repeat (5) cyc();
      edges(2);
      n_cmp++;
      if (dut_pulses !== 0) begin
         n_bad++;
         $display("FAIL hold_high_pulses: got %0d want 0", dut_pulses);
      end
      tick_src = 1'b1;
      cyc();
      n_cmp++;
      if (sec_pulse !== 1'b1 || dut_d !== tod_digits(m_tod) || dut_d !== 24'h000011) begin
         n_bad++;
         $display("FAIL hold_high_once: got pulse=%b %h want pulse=1 000011", sec_pulse, dut_d);
      end
      repeat (2) cyc();
      tick_src = 1'b0;
      repeat (5) cyc();
   endtask

   task automatic test_set_rollover();
      set_mode = 1'b1;
      cyc();
      n_cmp++;
      if (in_set !== 1'b1 || dut_d !== 24'h000000) begin
         n_bad++;
         $display("FAIL set_entry: got in_set=%b %h want in_set=1 000000", in_set, dut_d);
      end
      repeat (23) pulse_inc(0, 1);
      repeat (59) pulse_inc(1, 0);
      n_cmp++;
      if (dut_d !== 24'h235900) begin
         n_bad++;
         $display("FAIL set_max: got %h want 235900", dut_d);
      end
      pulse_inc(1, 1);
      n_cmp++;
      if (dut_d !== 24'h000000) begin
         n_bad++;
         $display("FAIL set_both_wrap: got %h want 000000", dut_d);
      end
      repeat (23) pulse_inc(0, 1);
      repeat (59) pulse_inc(1, 0);
      n_cmp++;
      if (dut_d !== 24'h235900) begin
         n_bad++;
         $display("FAIL set_max2: got %h want 235900", dut_d);
      end
      set_mode = 1'b0;
      cyc();
      dut_pulses = 0;
      edges(236);
      n_cmp++;
      if (dut_d !== 24'h235959 || in_set !== 1'b0) begin
         n_bad++;
         $display("FAIL pre_midnight: got %h in_set=%b want 235959 in_set=0", dut_d, in_set);
      end
      edges(4);
      n_cmp++;
      if (dut_d !== 24'h000000 || dut_pulses !== 60) begin
         n_bad++;
         $display("FAIL midnight: got %h pulses=%0d want 000000 pulses=60", dut_d, dut_pulses);
      end
   endtask

   task automatic test_set_entry();
      do_reset();
      tick_src = 1'b0;
      cyc();
      edges(37 * TPS + 2);
      inc_min = 1'b1;
      cyc();
      inc_min = 1'b0;
      n_cmp++;
      if (dut_d !== 24'h000037) begin
         n_bad++;
         $display("FAIL run_ignores_inc: got %h want 000037", dut_d);
      end
      set_mode = 1'b1;
      cyc();
      dut_pulses = 0;
      edges(10);
      n_cmp++;
      if (dut_d !== 24'h000000 || in_set !== 1'b1 || dut_pulses !== 0) begin
         n_bad++;
         $display("FAIL set_freeze: got %h in_set=%b pulses=%0d want 000000 1 0", dut_d, in_set, dut_pulses);
      end
      set_mode = 1'b0;
      cyc();
      edges(TPS - 1);
      n_cmp++;
      if (dut_pulses !== 0) begin
         n_bad++;
         $display("FAIL resume_early: got pulses=%0d want 0", dut_pulses);
      end
      edges(1);
      n_cmp++;
      if (dut_pulses !== 1 || dut_d !== 24'h000001) begin
         n_bad++;
         $display("FAIL resume_first: got pulses=%0d %h want 1 000001", dut_pulses, dut_d);
      end
   endtask

   task automatic test_reset_mid();
      set_mode = 1'b1;
      cyc();
      repeat (12) pulse_inc(0, 1);
      repeat (34) pulse_inc(1, 0);
      set_mode = 1'b0;
      cyc();
      edges(56 * TPS);
      n_cmp++;
      if (dut_d !== 24'h123456) begin
         n_bad++;
         $display("FAIL reach_123456: got %h want 123456", dut_d);
      end
      tick_src = 1'b1;
      do_reset();
      n_cmp++;
      if ({dut_d, sec_pulse, in_set} !== 26'd0) begin
         n_bad++;
         $display("FAIL reset_run: got %h/%b/%b want 000000/0/0", dut_d, sec_pulse, in_set);
      end
      dut_pulses = 0;
      repeat (2) cyc();
      tick_src = 1'b0;
      repeat (5) cyc();
      edges(TPS - 1);
      n_cmp++;
      if (dut_pulses !== 0) begin
         n_bad++;
         $display("FAIL no_spurious_edge: got pulses=%0d want 0", dut_pulses);
      end
      edges(1);
      n_cmp++;
      if (dut_pulses !== 1) begin
         n_bad++;
         $display("FAIL post_reset_sec: got pulses=%0d want 1", dut_pulses);
      end
      set_mode = 1'b1;
      cyc();
      pulse_inc(1, 1);
      do_reset();
      n_cmp++;
      if ({dut_d, sec_pulse, in_set} !== 26'd0) begin
         n_bad++;
         $display("FAIL reset_set: got %h/%b/%b want 000000/0/0", dut_d, sec_pulse, in_set);
      end
   endtask

   task automatic test_random();
      bit ok;
      ok = 1;
      dut_pulses = 0;
      mdl_pulses = 0;
      set_mode = 1'b1;
      for (int i = 0; i < 3000 && ok; i++) begin
         if ($urandom_range(0, 2) == 0) tick_src = ~tick_src;
         if ($urandom_range(0, 199) == 0) set_mode = ~set_mode;
         inc_min  = ($urandom_range(0, 3) == 0);
         inc_hour = ($urandom_range(0, 7) == 0);
         cyc();
         n_cmp++;
         if ({dut_d, sec_pulse, in_set} !== {tod_digits(m_tod), m_pulse, m_set}) begin
            n_bad++;
            ok = 0;
            $display("FAIL random_cycle %0d: got %h/%b/%b want %h/%b/%b", i, dut_d, sec_pulse, in_set,
                     tod_digits(m_tod), m_pulse, m_set);
         end
      end
      inc_min = 1'b0;
      inc_hour = 1'b0;
      n_cmp++;
      if (dut_pulses !== mdl_pulses) begin
         n_bad++;
         $display("FAIL random_pulses: got %0d want %0d", dut_pulses, mdl_pulses);
      end
   endtask

   initial begin
      RESETn = 1'b1;
      tick_src = 1'b0;
      set_mode = 1'b0;
      inc_min = 1'b0;
      inc_hour = 1'b0;
      m_tod = 0; m_pre = 0; m_set = 0; m_pulse = 0; m_prev = 0;
      dut_pulses = 0;
      mdl_pulses = 0;
      test_reset();
      test_seconds();
      test_hold_high();
      test_set_rollover();
      test_set_entry();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
